// File: rtl/mio_pkg.sv
// mio_arbiter shared definitions: grant states,
// address step and counter-width helper.
package mio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CPU  = 2'b01,
    GFX  = 2'b10,
    BAD  = 2'b11
  } mio_state_e;

  localparam int unsigned WORD_INC = 4;

  function automatic int unsigned cnt_w(
    input int unsigned n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mio_lat_cnt.sv
// Modulo-MEM_LAT access latency counter shared by
// the CPU and GFX grant states of mio_arbiter.
module mio_lat_cnt
  import mio_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int unsigned CW = cnt_w(MEM_LAT);

  generate
    if (MEM_LAT == 1) begin : g_single
      // every cycle is the final cycle of an access
      assign last = 1'b1;
    end else begin : g_multi
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;

      assign last = (cnt_q == CW'(MEM_LAT - 1));

      always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
          cnt_d = '0;
        end else if (en) begin
          cnt_d = last ? '0 : cnt_q + CW'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/mio_arbiter.sv
// CPU / graphics memory-port arbiter. Optional round-robin
// tie-break enabled by defining MIO_ARB_FAIR_EN.
module mio_arbiter
  import mio_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_LAT   = 2,
  parameter int unsigned GFX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              MIO_ready,
  input  logic              gfx_req,
  input  logic [ADDR_W-1:0] gfx_addr,
  output logic [DATA_W-1:0] gfx_rdata,
  output logic              gfx_valid,
  output logic              gfx_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        grant_state
);

  localparam int unsigned BW = cnt_w(GFX_BURST);

  mio_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BW-1:0]     beat_q;

  logic in_cpu;
  logic in_gfx;
  logic busy;
  logic lat_last;
  logic beat_last;
  logic pick_cpu;

  assign in_cpu    = (state_q == CPU);
  assign in_gfx    = (state_q == GFX);
  assign busy      = in_cpu | in_gfx;
  assign beat_last = (beat_q == BW'(GFX_BURST - 1));

  mio_lat_cnt #(
    .MEM_LAT(MEM_LAT)
  ) u_lat (
    .clk  (clk),
    .reset(reset),
    .clr  (~busy),
    .en   (busy),
    .last (lat_last)
  );

`ifdef MIO_ARB_FAIR_EN
  logic last_gfx_q;
  assign pick_cpu = cpu_req & (~gfx_req | last_gfx_q);
`else
  assign pick_cpu = cpu_req;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      beat_q  <= '0;
`ifdef MIO_ARB_FAIR_EN
      last_gfx_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          beat_q <= '0;
          if (pick_cpu) begin
            state_q <= CPU;
            addr_q  <= cpu_addr;
            we_q    <= cpu_we;
            wdata_q <= cpu_wdata;
`ifdef MIO_ARB_FAIR_EN
            last_gfx_q <= 1'b0;
`endif
          end else if (gfx_req) begin
            state_q <= GFX;
            addr_q  <= gfx_addr;
            we_q    <= 1'b0;
            wdata_q <= '0;
`ifdef MIO_ARB_FAIR_EN
            last_gfx_q <= 1'b1;
`endif
          end
        end
        CPU: begin
          if (lat_last) state_q <= IDLE;
        end
        GFX: begin
          if (lat_last) begin
            // wraps naturally at 2^ADDR_W
            addr_q <= addr_q + ADDR_W'(WORD_INC);
            if (beat_last) begin
              state_q <= IDLE;
            end else begin
              beat_q <= beat_q + BW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_state = state_q;
  assign mem_en      = busy;
  assign mem_we      = in_cpu & we_q;
  assign mem_addr    = busy ? addr_q : '0;
  assign mem_wdata   = in_cpu ? wdata_q : '0;

  assign MIO_ready = in_cpu & lat_last;
  assign cpu_rdata = MIO_ready ? mem_rdata : '0;
  assign gfx_valid = in_gfx & lat_last;
  assign gfx_done  = gfx_valid & beat_last;
  assign gfx_rdata = gfx_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_mio_arbiter.sv
// Self-checking bench for mio_arbiter: vector table,
// corner sequences and random traffic vs. a schedule model.
module tb_mio_arbiter;

  localparam int L = 2;
  localparam int B = 4;

  logic        clk = 1'b0;
  logic        reset, cpu_req, cpu_we, gfx_req;
  logic        MIO_ready, gfx_valid, gfx_done;
  logic        mem_en, mem_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [31:0] gfx_addr, gfx_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  grant_state;

  always #5 clk = ~clk;

  mio_arbiter #(
    .ADDR_W(32), .DATA_W(32),
    .MEM_LAT(L), .GFX_BURST(B)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .MIO_ready(MIO_ready),
    .gfx_req(gfx_req), .gfx_addr(gfx_addr),
    .gfx_rdata(gfx_rdata), .gfx_valid(gfx_valid),
    .gfx_done(gfx_done),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .grant_state(grant_state)
  );

  typedef struct packed {
    logic [1:0]  gs;
    logic        rdy;
    logic [31:0] crd;
    logic        en;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        gv;
    logic        gd;
    logic [31:0] grd;
  } out_t;

  typedef struct packed {
    logic        rst;
    logic        creq;
    logic        cwe;
    logic [31:0] caddr;
    logic [31:0] cwd;
    logic        greq;
    logic [31:0] gaddr;
    logic [31:0] mrd;
  } in_t;

  typedef struct {
    in_t  i;
    logic chk;
    out_t o;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic in_t mi(
    logic rst, logic creq, logic cwe,
    logic [31:0] caddr, logic [31:0] cwd,
    logic greq, logic [31:0] gaddr,
    logic [31:0] mrd);
    in_t r;
    r.rst = rst; r.creq = creq; r.cwe = cwe;
    r.caddr = caddr; r.cwd = cwd;
    r.greq = greq; r.gaddr = gaddr; r.mrd = mrd;
    return r;
  endfunction

  function automatic out_t mo(
    logic [1:0] gs, logic rdy, logic [31:0] crd,
    logic en, logic we, logic [31:0] addr,
    logic [31:0] wd, logic gv, logic gd,
    logic [31:0] grd);
    out_t o;
    o.gs = gs; o.rdy = rdy; o.crd = crd;
    o.en = en; o.we = we; o.addr = addr;
    o.wd = wd; o.gv = gv; o.gd = gd; o.grd = grd;
    return o;
  endfunction

  function automatic out_t act();
    return mo(grant_state, MIO_ready, cpu_rdata,
              mem_en, mem_we, mem_addr, mem_wdata,
              gfx_valid, gfx_done, gfx_rdata);
  endfunction

  function automatic string fmt(out_t o);
    return $sformatf(
      "gs=%0d rdy=%0b crd=%h en=%0b we=%0b addr=%h wd=%h gv=%0b gd=%0b grd=%h",
      o.gs, o.rdy, o.crd, o.en, o.we, o.addr,
      o.wd, o.gv, o.gd, o.grd);
  endfunction

  task automatic cmp(input string nm, input out_t e, input out_t a);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got {%s} want {%s}", nm, fmt(a), fmt(e));
    end
  endtask

  task automatic cmp1(input string nm, input logic [31:0] a,
                      input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic drive(input in_t r);
    reset = r.rst; cpu_req = r.creq; cpu_we = r.cwe;
    cpu_addr = r.caddr; cpu_wdata = r.cwd;
    gfx_req = r.greq; gfx_addr = r.gaddr;
    mem_rdata = r.mrd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input in_t r);
    tick();
    drive(r);
    @(negedge clk);
  endtask

  localparam out_t Z = '0;
  vec_t tv[19];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nv, nd, dk;
    logic [1:0] prev;
    logic [31:0] g[$];
    logic [31:0] exp3[3];
    out_t e;
    in_t r;
    int unsigned free_at, start, k;
    int kind;
    logic [31:0] maddr, mwd;
    logic mwe, lg_gfx, win_cpu;

    drive(mi(1, 0, 0, 0, 0, 0, 0, 0));

    tv[0]  = '{mi(1,0,0,0,0,0,0,0), 1'b0, Z};
    tv[1]  = '{mi(0,0,0,0,0,0,0,0), 1'b1, Z};
    tv[2]  = '{mi(0,1,0,'h100,0,0,0,0), 1'b1, Z};
    tv[3]  = '{mi(0,1,0,'h100,0,0,0,'h11111111), 1'b1,
               mo(1,0,0,1,0,'h100,0,0,0,0)};
    tv[4]  = '{mi(0,1,0,'h100,0,0,0,'hDEADBEEF), 1'b1,
               mo(1,1,'hDEADBEEF,1,0,'h100,0,0,0,0)};
    tv[5]  = '{mi(0,0,0,0,0,0,0,'h77), 1'b1, Z};
    tv[6]  = '{mi(0,1,1,'h40,'h1234,0,0,0), 1'b1, Z};
    tv[7]  = '{mi(0,1,1,'h40,'h1234,0,0,0), 1'b1,
               mo(1,0,0,1,1,'h40,'h1234,0,0,0)};
    tv[8]  = '{mi(0,1,1,'h40,'h1234,0,0,'h55), 1'b1,
               mo(1,1,'h55,1,1,'h40,'h1234,0,0,0)};
    tv[9]  = '{mi(0,0,0,0,0,1,'hFFFFFFF8,0), 1'b1, Z};
    tv[10] = '{mi(0,0,0,0,0,0,0,'h99), 1'b1,
               mo(2,0,0,1,0,'hFFFFFFF8,0,0,0,0)};
    tv[11] = '{mi(0,0,0,0,0,0,0,'hA0), 1'b1,
               mo(2,0,0,1,0,'hFFFFFFF8,0,1,0,'hA0)};
    tv[12] = '{mi(0,0,0,0,0,0,0,'h99), 1'b1,
               mo(2,0,0,1,0,'hFFFFFFFC,0,0,0,0)};
    tv[13] = '{mi(0,0,0,0,0,0,0,'hA1), 1'b1,
               mo(2,0,0,1,0,'hFFFFFFFC,0,1,0,'hA1)};
    tv[14] = '{mi(0,0,0,0,0,0,0,'h99), 1'b1,
               mo(2,0,0,1,0,'h0,0,0,0,0)};
    tv[15] = '{mi(0,0,0,0,0,0,0,'hA2), 1'b1,
               mo(2,0,0,1,0,'h0,0,1,0,'hA2)};
    tv[16] = '{mi(0,0,0,0,0,0,0,'h99), 1'b1,
               mo(2,0,0,1,0,'h4,0,0,0,0)};
    tv[17] = '{mi(0,0,0,0,0,0,0,'hA3), 1'b1,
               mo(2,0,0,1,0,'h4,0,1,1,'hA3)};
    tv[18] = '{mi(0,0,0,0,0,0,0,'h99), 1'b1, Z};

    foreach (tv[n]) begin
      step(tv[n].i);
      if (tv[n].chk)
        cmp($sformatf("vec%0d", n), tv[n].o, act());
    end

    // tie held continuously; the last grant above was GFX
`ifdef MIO_ARB_FAIR_EN
    exp3 = '{32'd1, 32'd2, 32'd1};
`else
    exp3 = '{32'd1, 32'd1, 32'd1};
`endif
    prev = 2'd0;
    for (int c = 0; c < 40 && g.size() < 3; c++) begin
      step(mi(0, 1, 0, 'h700, 'h5, 1, 'h800, 0));
      if (prev == 2'd0 && grant_state != 2'd0)
        g.push_back(32'(grant_state));
      prev = grant_state;
    end
    cmp1("tie_grant_count", g.size(), 3);
    for (int i = 0; i < g.size() && i < 3; i++)
      cmp1($sformatf("tie_grant%0d", i), g[i], exp3[i]);

    for (int c = 0; c < 20; c++) begin
      step(mi(0, 0, 0, 0, 0, 0, 0, 0));
      if (grant_state == 2'd0) break;
    end
    cmp1("drain_idle", grant_state, 0);

    // cpu_req arriving mid-burst waits for the next IDLE
    step(mi(0, 0, 0, 0, 0, 1, 'h200, 0));
    cmp1("s2_idle", grant_state, 0);
    nv = 0;
    dk = 0;
    for (int j = 1; j <= 8; j++) begin
      step(mi(0, j >= 3, 0, 'h300, 0, 0, 0, 32'hC0 + j));
      if (j == 1) cmp1("s2_gfx", grant_state, 2);
      nv += int'(gfx_valid);
      if (gfx_done) dk = j;
    end
    cmp1("s2_valids", nv, 4);
    cmp1("s2_done_at", dk, 8);
    step(mi(0, 1, 0, 'h300, 0, 0, 0, 'h1));
    cmp1("s2_idle_gap", grant_state, 0);
    step(mi(0, 1, 0, 'h300, 0, 0, 0, 'h2));
    cmp("s2_cpu", mo(1,0,0,1,0,'h300,0,0,0,0), act());
    step(mi(0, 1, 0, 'h300, 0, 0, 0, 'h3));
    cmp("s2_ready", mo(1,1,'h3,1,0,'h300,0,0,0,0), act());
    step(mi(0, 0, 0, 0, 0, 0, 0, 0));

    // reset during beat 2 aborts the burst
    step(mi(0, 0, 0, 0, 0, 1, 'h500, 0));
    nv = 0;
    nd = 0;
    for (int j = 1; j <= 5; j++) begin
      step(mi(j == 5, 0, 0, 0, 0, 0, 0, 32'hE0 + j));
      nv += int'(gfx_valid);
      nd += int'(gfx_done);
      if (j == 5) cmp1("s3_in_gfx", grant_state, 2);
    end
    step(mi(0, 1, 1, 'h600, 'hAB, 0, 0, 'h9));
    nd += int'(gfx_done);
    cmp("s3_after_reset", Z, act());
    cmp1("s3_valids", nv, 2);
    cmp1("s3_no_done", nd, 0);
    step(mi(0, 1, 1, 'h600, 'hAB, 0, 0, 'h9));
    cmp("s3_cpu", mo(1,0,0,1,1,'h600,'hAB,0,0,0), act());
    step(mi(0, 1, 1, 'h600, 'hAB, 0, 0, 'hA));
    cmp("s3_ready", mo(1,1,'hA,1,1,'h600,'hAB,0,0,0), act());

    // random traffic against a cycle-schedule model
    step(mi(1, 0, 0, 0, 0, 0, 0, 0));
    free_at = 0;
    start = 0;
    kind = 0;
    lg_gfx = 1'b0;
    maddr = '0;
    mwd = '0;
    mwe = 1'b0;
    for (int unsigned c = 1; c <= 2000; c++) begin
      r.rst = ($urandom_range(0, 63) == 0);
      r.creq = 1'($urandom_range(0, 1));
      r.cwe = 1'($urandom_range(0, 1));
      r.caddr = $urandom;
      r.cwd = $urandom;
      r.greq = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0)
        r.gaddr = 32'hFFFFFFF0 + 32'(4 * $urandom_range(0, 3));
      else
        r.gaddr = $urandom & 32'hFFFFFFFC;
      r.mrd = $urandom;
      step(r);

      e = '0;
      if (c < free_at) begin
        k = c - start;
        e.en = 1'b1;
        if (kind == 1) begin
          e.gs = 2'd1;
          e.we = mwe;
          e.addr = maddr;
          e.wd = mwd;
          e.rdy = (k == L);
          e.crd = e.rdy ? r.mrd : '0;
        end else begin
          e.gs = 2'd2;
          e.addr = maddr + 32'(4 * ((k - 1) / L));
          e.gv = ((k % L) == 0);
          e.gd = e.gv && (k == B * L);
          e.grd = e.gv ? r.mrd : '0;
        end
      end
      cmp($sformatf("rand_c%0d", c), e, act());

      if (r.rst) begin
        free_at = 0;
        lg_gfx = 1'b0;
      end else if (c >= free_at && (r.creq || r.greq)) begin
`ifdef MIO_ARB_FAIR_EN
        win_cpu = r.creq && (!r.greq || lg_gfx);
`else
        win_cpu = r.creq;
`endif
        start = c;
        kind = win_cpu ? 1 : 2;
        free_at = c + (win_cpu ? L : B * L) + 1;
        maddr = win_cpu ? r.caddr : r.gaddr;
        mwd = r.cwd;
        mwe = r.cwe;
        lg_gfx = !win_cpu;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mio_arbiter.md
# mio_arbiter

Memory-port arbiter sharing the single external memory/MIO bus between the multicycle CPU controller and a graphics read master (display refresh). Grants one requester at a time, sequences fixed-latency memory accesses, and generates the CPU's `MIO_ready` wait handshake. It sits between the CPU datapath/controller and the memory/peripheral bus.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `MEM_LAT`, 2, cycles per memory access (≥1).
- `GFX_BURST`, 4, words per graphics burst (≥1).

- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `cpu_req`  in  1  CPU access request (driven by CPU_MIO).
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  ADDR_W  CPU byte address.
- `cpu_wdata`  in  DATA_W  CPU write data.
- `cpu_rdata`  out  DATA_W  read data, valid while `MIO_ready`=1.
- `MIO_ready`  out  1  one-cycle access-complete pulse to CPU.
- `gfx_req`  in  1  graphics burst request.
- `gfx_addr`  in  ADDR_W  burst start address (word-aligned).
- `gfx_rdata`  out  DATA_W  burst read data.
- `gfx_valid`  out  1  one-cycle pulse per burst word.
- `gfx_done`  out  1  pulse with last word of burst.
- `mem_en`, `mem_we`  out  1  memory strobe / write enable.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, valid in last cycle of each access.
- `grant_state`  out  2  current FSM state.

## Operation
- States: IDLE (2'b00), CPU (2'b01), GFX (2'b10). 2'b11 is unreachable; if entered, go to IDLE.
- IDLE: sample requests.
  - Only `cpu_req` → CPU.
  - Only `gfx_req` → GFX.
  - Both → tie resolved per Configuration.
  - On grant, latch `cpu_addr`/`cpu_we`/`cpu_wdata` or `gfx_addr` into internal registers. The memory port drives only the latched values.
- CPU: `mem_en`=1 and `mem_we`=latched `cpu_we` for MEM_LAT cycles.
  - Latency counter runs 0..MEM_LAT-1.
  - At count MEM_LAT-1: `MIO_ready`=1 and `cpu_rdata`=`mem_rdata` (combinational pass-through). Next state is IDLE.
  - If `cpu_req` drops mid-access, the access still completes and `MIO_ready` still pulses.
- GFX: reads only (`mem_we`=0).
  - Beat counter 0..GFX_BURST-1. Each beat takes MEM_LAT cycles.
  - At the end of each beat: `gfx_valid`=1, `gfx_rdata`=`mem_rdata`, address increments by 4, wrapping modulo 2^ADDR_W.
  - On the last beat `gfx_done`=1 with `gfx_valid`. Next state is IDLE.
  - The burst is never pre-empted by `cpu_req`.
- After every grant, at least one IDLE cycle occurs before the next grant.
- `mem_en`=0 in IDLE. `mem_addr`, `mem_wdata`, `mem_we`, `cpu_rdata`, `gfx_rdata` read 0 when not granted.

## Timing
- Reset (synchronous):
  - State → IDLE, counters → 0, latched registers → 0.
  - All outputs 0 on the cycle after reset is sampled.
  - Reset mid-burst aborts the burst without `gfx_done`. Reset mid-CPU-access aborts without `MIO_ready`.
- CPU latency: request seen in IDLE at cycle t → `MIO_ready` at cycle t+MEM_LAT. The CPU holds `cpu_req` and its address until `MIO_ready`.
- GFX burst: `gfx_valid` at cycles t+k·MEM_LAT for k=1..GFX_BURST. The last of these also carries `gfx_done`.
- MEM_LAT=1: an access completes in its entry cycle. The counter is unused.
- Requests asserted outside IDLE are not queued; they are resampled at the next IDLE.

## Configuration
- Macro `MIO_ARB_FAIR_EN`.
- Defined: round-robin tie-break using a `last_grant` flag (reset value CPU).
  - A tie after a CPU grant goes to GFX.
  - A tie after a GFX grant goes to CPU.
- Undefined: fixed priority; the CPU always wins a tie. `last_grant` is not implemented.

## Structure
- Package `mio_pkg`:
  - State localparams IDLE/CPU/GFX.
  - `WORD_INC`=4.
- Sub-module `mio_lat_cnt`: modulo-MEM_LAT counter with `clr`, `en`, and a `last` flag output. It is instantiated once and shared by both grant states.
- The beat counter lives in the top module.

## Test plan
- Reset → `grant_state`=0; `MIO_ready`, `mem_en`, `gfx_valid` all 0. Then CPU read of `0x100` with `mem_rdata`=`0xDEADBEEF`, MEM_LAT=2 → `MIO_ready` 2 cycles after request, `cpu_rdata`=`0xDEADBEEF`.
- CPU write to `0x40`, data `0x1234` → `mem_we`=1 and `mem_addr`=`0x40` for 2 cycles, then one `MIO_ready` pulse.
- GFX burst at `0xFFFFFFF8`, GFX_BURST=4 → `mem_addr` sequence F8, FC, 00, 04 (wrap); 4 `gfx_valid` pulses; `gfx_done` on the 4th.
- Simultaneous `cpu_req`+`gfx_req` held continuously:
  - Without macro → CPU is granted at every tie.
  - With `MIO_ARB_FAIR_EN` → grants alternate CPU, GFX, CPU.
- `cpu_req` arrives during a GFX burst → burst completes; the CPU is granted at the next IDLE, with `MIO_ready` MEM_LAT cycles after that.
- Reset asserted at beat 2 of a burst → IDLE next cycle; no `gfx_done`; the next request is serviced normally.
